// File: rtl/jk_arb_pkg.sv
// Shared types and constants for the JK operation arbiter: FSM states,
// op encodings and the op-to-j/k mapping.
package jk_arb_pkg;

    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_HOLD = 2'b00;
    localparam logic [OP_W-1:0] OP_CLR  = 2'b01;
    localparam logic [OP_W-1:0] OP_SET  = 2'b10;
    localparam logic [OP_W-1:0] OP_TGL  = 2'b11;

    // Returns {j, k} for an op code.
    function automatic logic [1:0] op_to_jk(input logic [OP_W-1:0] op);
        logic [1:0] jk;
        case (op)
            OP_CLR:  jk = 2'b01;
            OP_SET:  jk = 2'b10;
            OP_TGL:  jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK bit: a D flip-flop fed by d = (j & ~q) | (~k & q),
// asynchronously cleared by active-low rst_n.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic d;

    assign d = (j & ~q) | (~k & q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/jk_op_arbiter.sv
// Round-robin arbiter letting NREQ requesters apply masked JK ops to a shared
// WIDTH-bit register. Optional completed-op counter enabled by JK_ARB_CNT_EN.
module jk_op_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0]    req_mask,
    output logic [NREQ-1:0]          req_ready,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qbar,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
`ifdef JK_ARB_CNT_EN
    ,
    output logic [15:0]              op_count
`endif
);

    localparam int IW = $clog2(NREQ);

    state_t              state;
    logic                found;
    logic [IW-1:0]       win;
    logic [OP_W-1:0]     op_lat;
    logic [WIDTH-1:0]    mask_lat;
    logic [1:0]          jk_sel;
    logic [WIDTH-1:0]    j;
    logic [WIDTH-1:0]    k;

    // Round-robin search starting one past the last grant.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(grant_id) + i) % NREQ;
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign jk_sel = op_to_jk(op_lat);

    always_comb begin
        j = '0;
        k = '0;
        if (state == APPLY) begin
            j = jk_sel[1] ? mask_lat : '0;
            k = jk_sel[0] ? mask_lat : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= IW'(NREQ - 1);
            req_ready <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= APPLY;
                        grant_id <= win;
                        busy     <= 1'b1;
                    end
                end
                APPLY: begin
                    state     <= ACK;
                    req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
                end
                ACK: begin
                    state     <= IDLE;
                    req_ready <= '0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture on the grant edge; the op in flight ignores later input changes.
    always_ff @(posedge clk) begin
        if (state == IDLE && found) begin
            op_lat   <= req_op[int'(win)*OP_W +: OP_W];
            mask_lat <= req_mask[int'(win)*WIDTH +: WIDTH];
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[b]),
            .k     (k[b]),
            .q     (q[b])
        );
    end

    assign qbar = ~q;

`ifdef JK_ARB_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (state == ACK && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_op_arbiter.sv
// Directed bench for jk_op_arbiter (NREQ=4, WIDTH=8); the op counter checks
// are included when JK_ARB_CNT_EN is defined.
module tb_jk_op_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [31:0] req_mask;
    logic [3:0]  req_ready;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef JK_ARB_CNT_EN
    logic [15:0] op_count;
`endif

    int errors = 0;
    int checks = 0;

    jk_op_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_mask  (req_mask),
        .req_ready (req_ready),
        .q         (q),
        .qbar      (qbar),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef JK_ARB_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [1:0] op, input logic [7:0] mask);
        req_valid[id]       = v;
        req_op[id*2 +: 2]   = op;
        req_mask[id*8 +: 8] = mask;
    endtask

    task automatic do_op(input int id, input logic [1:0] op, input logic [7:0] mask);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        set_req(id, 1'b1, op, mask);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        check("do_op_ready", {31'd0, seen}, 32'd1);
        set_req(id, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] any_ready;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_mask  = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_qbar", {24'd0, qbar}, 32'hFF);
        check("rst_ready", {28'd0, req_ready}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gid", {30'd0, grant_id}, 32'd3);
        rst_n = 1'b1;

        // Single set op by requester 0
        set_req(0, 1'b1, 2'b10, 8'h0F);
        @(negedge clk);
        check("set_busy", {31'd0, busy}, 32'd1);
        check("set_gid", {30'd0, grant_id}, 32'd0);
        check("set_q_pre", {24'd0, q}, 32'h00);
        @(negedge clk);
        check("set_q", {24'd0, q}, 32'h0F);
        check("set_qbar", {24'd0, qbar}, 32'hF0);
        check("set_ready", {28'd0, req_ready}, 32'h1);
        set_req(0, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        check("set_ready_off", {28'd0, req_ready}, 32'h0);
        check("set_idle", {31'd0, busy}, 32'd0);

        // Toggle by requester 2
        set_req(2, 1'b1, 2'b11, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("tgl_q", {24'd0, q}, 32'hF0);
        check("tgl_gid", {30'd0, grant_id}, 32'd2);
        check("tgl_ready", {28'd0, req_ready}, 32'h4);
        set_req(2, 1'b0, 2'b00, 8'h00);
        @(negedge clk);

        // Mask change after grant must not affect the op in flight
        set_req(1, 1'b1, 2'b10, 8'h01);
        @(negedge clk);
        req_mask[15:8] = 8'hFF;
        @(negedge clk);
        check("latch_q", {24'd0, q}, 32'hF1);
        check("latch_gid", {30'd0, grant_id}, 32'd1);
        set_req(1, 1'b0, 2'b00, 8'h00);
        @(negedge clk);

        // Hold op still handshakes
        set_req(3, 1'b1, 2'b00, 8'hFF);
        @(negedge clk);
        check("hold_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("hold_q", {24'd0, q}, 32'hF1);
        check("hold_ready", {28'd0, req_ready}, 32'h8);
        set_req(3, 1'b0, 2'b00, 8'h00);
        @(negedge clk);

        // Requester 3 drops valid before it can be granted
        set_req(1, 1'b1, 2'b01, 8'h01);
        @(negedge clk);
        set_req(3, 1'b1, 2'b10, 8'h02);
        @(negedge clk);
        check("drop_q", {24'd0, q}, 32'hF0);
        check("drop_ready", {28'd0, req_ready}, 32'h2);
        set_req(1, 1'b0, 2'b00, 8'h00);
        set_req(3, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("drop_busy", {31'd0, busy}, 32'd0);
        check("drop_gid", {30'd0, grant_id}, 32'd1);

        // Contention from reset: grants 0,1,2,3 spaced 3 cycles apart
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b10, 8'(1 << i));
        for (int c = 1; c <= 12; c++) begin
            logic [3:0] exp_r;
            @(negedge clk);
            exp_r = (c % 3 == 2) ? 4'(1 << ((c - 2) / 3)) : 4'h0;
            check($sformatf("cont_ready_%0d", c), {28'd0, req_ready}, {28'd0, exp_r});
            for (int i = 0; i < 4; i++) if (req_ready[i]) req_valid[i] = 1'b0;
        end
        check("cont_q", {24'd0, q}, 32'h0F);
        check("cont_gid", {30'd0, grant_id}, 32'd3);
        req_valid = '0;
        @(negedge clk);

        // Reset during APPLY aborts the op
        set_req(2, 1'b1, 2'b10, 8'hFF);
        @(negedge clk);
        check("abort_gid_pre", {30'd0, grant_id}, 32'd2);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("abort_q", {24'd0, q}, 32'h00);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_gid", {30'd0, grant_id}, 32'd3);
        any_ready = req_ready;
        @(negedge clk);
        any_ready |= req_ready;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            any_ready |= req_ready;
        end
        check("abort_no_ready", {28'd0, any_ready}, 32'h0);
        check("abort_q_hold", {24'd0, q}, 32'h00);
        set_req(0, 1'b1, 2'b11, 8'h01);
        set_req(2, 1'b1, 2'b11, 8'h02);
        @(negedge clk);
        check("after_rst_gid", {30'd0, grant_id}, 32'd0);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("after_rst_q", {24'd0, q}, 32'h01);

`ifdef JK_ARB_CNT_EN
        // Completed-op counter and saturation
        rst_n = 1'b0;
        @(negedge clk);
        check("cnt_rst", {16'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        do_op(0, 2'b10, 8'h01);
        do_op(1, 2'b10, 8'h02);
        do_op(2, 2'b00, 8'hFF);
        check("cnt_three", {16'd0, op_count}, 32'd3);
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        do_op(3, 2'b11, 8'h80);
        check("cnt_sat", {16'd0, op_count}, 32'hFFFF);
`else
        do_op(3, 2'b10, 8'h80);
        check("final_q", {24'd0, q}, 32'h81);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/jk_op_arbiter.md
JK_OP_ARBITER -- requirements
Module: jk_op_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the number of JK flip-flop bits in the shared register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester operation request.
REQ-006 The block SHALL have port req_op, input, 2*NREQ bits: per-requester op, 2 bits each, with 00=hold, 01=clear (k), 10=set (j), 11=toggle (j,k).
REQ-007 The block SHALL have port req_mask, input, WIDTH*NREQ bits: per-requester bit-select mask.
REQ-008 The block SHALL have port req_ready, output, NREQ bits: one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port q, output, WIDTH bits: shared register state.
REQ-010 The block SHALL have port qbar, output, WIDTH bits: always the bitwise inverse of q.
REQ-011 The block SHALL have port grant_id, output, $clog2(NREQ) bits: index of the current or last granted requester.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states, IDLE, APPLY and ACK, and SHALL transition IDLE->APPLY when any req_valid is high, APPLY->ACK always, and ACK->IDLE always.
REQ-014 In IDLE, the block SHALL grant round-robin: search starts at (last grant + 1) mod NREQ, and the first requester with req_valid high wins.
REQ-015 On the grant edge, the block SHALL latch the winner's req_op and req_mask; later changes on the inputs SHALL NOT affect the operation in flight.
REQ-016 In APPLY, the block SHALL drive per-bit j/k from the latched op ANDed with the mask; unmasked bits get j=k=0 (hold).
REQ-017 The JK update SHALL follow j/k: 00 -> q unchanged, 01 -> q=0, 10 -> q=1, 11 -> q=~q.
REQ-018 q SHALL reflect the update at the APPLY->ACK edge.
REQ-019 In ACK, req_ready[grant_id] SHALL be high for exactly one cycle; all other req_ready bits SHALL stay 0.
REQ-020 Latency SHALL be: req_valid sampled at edge N -> q updated at edge N+1 -> req_ready high for cycle N+1..N+2 -> next grant possible at edge N+3.
REQ-021 A requester SHALL hold req_valid until it sees req_ready; if req_valid is still high in the IDLE cycle after ACK, the block SHALL treat it as a new request.
REQ-022 Operations SHALL NOT be dropped when requests arrive together: with all NREQ requesting, each requester SHALL be granted once within NREQ grants.
REQ-023 A requester that drops req_valid before grant SHALL NOT be granted.
REQ-024 Op 00 SHALL still complete the full handshake with q unchanged.

Reset
REQ-025 While rst_n is low, q SHALL be 0, qbar all-ones, req_ready 0, busy 0, and grant_id NREQ-1 (so that requester 0 is granted first).
REQ-026 Reset asserted mid-operation SHALL abort immediately: the FSM goes to IDLE and no req_ready pulse is issued.
REQ-027 After rst_n deasserts, the first grant SHALL be possible at the first rising edge.

Configuration
REQ-028 When macro JK_ARB_CNT_EN is defined, the block SHALL add output op_count, 16 bits: the count of completed operations, incremented in ACK, saturating at 0xFFFF, reset to 0.
REQ-029 When JK_ARB_CNT_EN is undefined, op_count and its counter SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 A shared package jk_arb_pkg SHALL hold the FSM state enum (IDLE/APPLY/ACK), the op encodings (OP_HOLD, OP_CLR, OP_SET, OP_TGL) and the op field width constant.
REQ-031 A sub-module jk_cell SHALL implement one JK bit as a D flip-flop with next-state logic d = (j & ~q) | (~k & q), with async active-low reset to 0, and the block SHALL instantiate it WIDTH times.

Verification
REQ-032 Reset then single op: requester 0 issues op 10 with mask 0x0F -> q=0x0F two edges later, req_ready[0] pulses once, qbar=0xF0.
REQ-033 Toggle: from q=0x0F, requester 2 issues op 11 with mask 0xFF -> q=0xF0, grant_id=2.
REQ-034 Contention: all 4 requesters hold valid from idle after reset -> grant order 0,1,2,3 -> each req_ready pulses once, spaced 3 cycles apart.
REQ-035 Mid-op reset: rst_n pulled low during APPLY -> q=0, busy=0, no req_ready pulse; after release requester 0 is granted first.
REQ-036 Input change after grant: req_mask changes 0x01->0xFF during APPLY with op 10 -> only bit 0 is set.
REQ-037 With JK_ARB_CNT_EN, 3 completed operations -> op_count=3; with the counter preloaded to 0xFFFF, one more operation -> op_count stays 0xFFFF.
